// File: rtl/bus_initiator_if.sv
// Memory-bus signal bundle between a load/store initiator and a waitrequest-stalling slave.
// Handshake: the master holds address/read/write/writedata/byteenable stable while waitrequest is high;
// the transfer completes at the rising edge where waitrequest is low, and readdata is valid in that cycle.
interface bus_initiator_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/bus_initiator.sv
// Turns single core load/store requests into memory-bus transactions with lane steering,
// load extension, alignment checking and an optional stall timeout.
module bus_initiator #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        core_req,
   input  logic        core_write,
   input  logic [31:0] core_addr,
   input  logic [1:0]  core_size,
   input  logic        core_signed,
   input  logic [31:0] core_wdata,
   output logic        core_busy,
   output logic        core_done,
   output logic        core_err,
   output logic [31:0] core_rdata,
   output logic        dbg_state,
   bus_initiator_if.master bus
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   // A zero timeout still needs a legal one-bit counter.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    lat_lo;
   logic [1:0]    lat_size;
   logic          lat_signed;

   logic          req_ok;
   logic [3:0]    be_n;
   logic [31:0]   wd_n;
   logic [31:0]   rd_shift;
   logic [15:0]   lane_h;
   logic [31:0]   ld_data;

   always_comb begin
      req_ok = 1'b0;
      be_n   = 4'b0000;
      wd_n   = core_wdata;
      case (core_size)
         2'b00: begin
            req_ok = 1'b1;
            be_n   = 4'b0001 << core_addr[1:0];
            wd_n   = {4{core_wdata[7:0]}};
         end
         2'b01: begin
            req_ok = !core_addr[0];
            be_n   = core_addr[1] ? 4'b1100 : 4'b0011;
            wd_n   = {2{core_wdata[15:0]}};
         end
         2'b10: begin
            req_ok = (core_addr[1:0] == 2'b00);
            be_n   = 4'b1111;
         end
         default: req_ok = 1'b0;
      endcase
   end

   // Lane selection uses the request attributes latched on entry to REQ.
   always_comb begin
      rd_shift = bus.readdata >> {lat_lo, 3'b000};
      lane_h   = lat_lo[1] ? bus.readdata[31:16] : bus.readdata[15:0];
      case (lat_size)
         2'b00:   ld_data = lat_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
         2'b01:   ld_data = lat_signed ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
         default: ld_data = bus.readdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         lat_lo         <= 2'b00;
         lat_size       <= 2'b00;
         lat_signed     <= 1'b0;
         core_done      <= 1'b0;
         core_err       <= 1'b0;
         core_rdata     <= '0;
         bus.address    <= '0;
         bus.read       <= 1'b0;
         bus.write      <= 1'b0;
         bus.writedata  <= '0;
         bus.byteenable <= '0;
      end else begin
         core_done <= 1'b0;
         core_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (core_req) begin
                  if (req_ok) begin
                     bus.address    <= {core_addr[31:2], 2'b00};
                     bus.byteenable <= be_n;
                     bus.writedata  <= wd_n;
                     bus.read       <= !core_write;
                     bus.write      <= core_write;
                     lat_lo         <= core_addr[1:0];
                     lat_size       <= core_size;
                     lat_signed     <= core_signed;
                     cnt            <= '0;
                     state          <= REQ;
                  end else begin
                     core_err <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (!bus.waitrequest) begin
                  bus.read  <= 1'b0;
                  bus.write <= 1'b0;
                  core_done <= 1'b1;
                  if (bus.read) core_rdata <= ld_data;
                  state <= IDLE;
               end else if ((TIMEOUT_CYCLES > 0) && (cnt == T_LAST)) begin
                  // Abort: the slave never answered; core_rdata keeps its previous load.
                  bus.read  <= 1'b0;
                  bus.write <= 1'b0;
                  core_err  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign core_busy = (state == REQ);
   assign dbg_state = state;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator against a small stalling memory model.
module tb_bus_initiator;
  localparam int TO = 8;
  localparam int W  = 34;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        core_req = 1'b0, core_write = 1'b0, core_signed = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [1:0]  core_size = 2'b00;
  logic        core_busy, core_done, core_err, dbg_state;
  logic [31:0] core_rdata;

  bus_initiator_if bus ();

  bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .core_req(core_req), .core_write(core_write),
    .core_addr(core_addr), .core_size(core_size), .core_signed(core_signed),
    .core_wdata(core_wdata), .core_busy(core_busy), .core_done(core_done),
    .core_err(core_err), .core_rdata(core_rdata), .dbg_state(dbg_state), .bus(bus)
  );

  // ---------------- memory slave model ----------------
  logic [31:0] mem [0:15];
  int          stalls_cfg = 0;
  int          stall_cnt = 0;
  logic        tie_wait = 1'b0;
  logic        bd_en = 1'b0;
  logic [3:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always_comb begin
    bus.waitrequest = 1'b1;
    if ((bus.read || bus.write) && !tie_wait && (stall_cnt == stalls_cfg)) bus.waitrequest = 1'b0;
    bus.readdata = mem[bus.address[5:2]];
  end

  always_ff @(posedge clk) begin
    if ((bus.read || bus.write) && bus.waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (bd_en) mem[bd_idx] <= bd_data;
    else if (bus.write && !bus.waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mem[bus.address[5:2]][8*b +: 8] <= bus.writedata[8*b +: 8];
    end
  end

  // ---------------- scoreboard and observations ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] got_v;

  logic        o_done, o_err, o_stable, o_rd, o_wr, o_gap;
  int          o_edges, o_act;
  logic [31:0] o_addr, o_wd, o_rdata;
  logic [3:0]  o_be;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] lo,
                                      input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  task automatic bd_write(input logic [3:0] idx, input logic [31:0] data);
    bd_en = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge; returns in the done/err cycle.
  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] wd);
    core_req = 1'b1; core_write = wr; core_addr = addr; core_size = sz;
    core_signed = sg; core_wdata = wd;
    @(posedge clk); #1;
    core_req = 1'b0;
    o_addr = bus.address; o_be = bus.byteenable; o_wd = bus.writedata;
    o_rd = bus.read; o_wr = bus.write;
    o_stable = 1'b1; o_edges = 0; o_act = 0;
    while (!core_done && !core_err && o_edges < 64) begin
      if (bus.read || bus.write) o_act++;
      if (core_busy !== (bus.read || bus.write)) o_stable = 1'b0;
      if ((bus.read || bus.write) && (bus.address !== o_addr || bus.byteenable !== o_be ||
          bus.writedata !== o_wd || bus.read !== o_rd || bus.write !== o_wr)) o_stable = 1'b0;
      @(posedge clk); #1;
      o_edges++;
    end
    o_done = core_done; o_err = core_err; o_rdata = core_rdata;
    o_gap = !(bus.read || bus.write);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.read, bus.write, bus.address, bus.byteenable, bus.writedata, core_busy, core_done,
         core_err, core_rdata, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: read=%b write=%b addr=%h be=%b wd=%h busy=%b done=%b err=%b rdata=%h state=%b, all required 0",
               bus.read, bus.write, bus.address, bus.byteenable, bus.writedata, core_busy,
               core_done, core_err, core_rdata, dbg_state);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({core_busy, bus.read, bus.write, dbg_state} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy/read/write/state=%b required 0000",
               {core_busy, bus.read, bus.write, dbg_state});
    end
  endtask

  task automatic test_word_load;
    bd_write(4'd4, 32'hDEADBEEF);
    stalls_cfg = 3;
    exp_q.push_back({2'b01, 32'hDEADBEEF});
    drive_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    checks++;
    if ({o_addr, o_be, o_rd, o_wr} !== {32'h10, 4'b1111, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL word_load_bus: addr=%h be=%b rd=%b wr=%b required 00000010 1111 1 0", o_addr, o_be, o_rd, o_wr);
    end
    checks++;
    if (!o_stable || o_edges !== 4 || o_act !== 4 || !o_gap) begin
      failures++;
      $display("FAIL word_load_timing: stable=%b edges=%0d active=%0d gap=%b required 1 4 4 1", o_stable, o_edges, o_act, o_gap);
    end
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL word_load_result: got %h required %h", got_v, exp_v);
    end
    @(posedge clk); #1;
    checks++;
    if (core_done !== 1'b0) begin
      failures++;
      $display("FAIL word_load_done_pulse: done=%b in following cycle, required 0", core_done);
    end
  endtask

  task automatic test_byte_load;
    bd_write(4'd4, 32'h80FF7F01);
    stalls_cfg = 1;
    for (int s = 1; s >= 0; s--) begin
      exp_q.push_back({2'b01, (s == 1) ? 32'hFFFFFF80 : 32'h00000080});
      drive_req(1'b0, 32'h13, 2'b00, s[0], 32'h0);
      checks++;
      if (o_be !== 4'b1000 || o_addr !== 32'h10) begin
        failures++;
        $display("FAIL byte_load_be: be=%b addr=%h required 1000 00000010", o_be, o_addr);
      end
      exp_v = exp_q.pop_front();
      got_v = {o_err, o_done, o_rdata};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL byte_load_result signed=%0d: got %h required %h", s, got_v, exp_v);
      end
    end
  endtask

  task automatic test_half_store;
    logic [31:0] prev;
    bd_write(4'd8, 32'h11223344);
    stalls_cfg = 2;
    prev = core_rdata;
    exp_q.push_back({2'b01, prev});
    drive_req(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000ABCD);
    checks++;
    if ({o_addr, o_be, o_wd, o_rd, o_wr} !== {32'h20, 4'b1100, 32'hABCDABCD, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL half_store_bus: addr=%h be=%b wd=%h rd=%b wr=%b required 00000020 1100 abcdabcd 0 1",
               o_addr, o_be, o_wd, o_rd, o_wr);
    end
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL half_store_result: got %h required %h", got_v, exp_v);
    end
    stalls_cfg = 0;
    exp_q.push_back({2'b01, 32'hABCD3344});
    @(posedge clk); #1;
    drive_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v || o_edges !== 1) begin
      failures++;
      $display("FAIL half_store_readback: got %h edges=%0d required %h edges=1", got_v, o_edges, exp_v);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] m_addr [3];
    logic [1:0]  m_size [3];
    m_addr[0] = 32'h06; m_size[0] = 2'b10;
    m_addr[1] = 32'h01; m_size[1] = 2'b01;
    m_addr[2] = 32'h00; m_size[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b10, core_rdata});
      drive_req(1'b0, m_addr[i], m_size[i], 1'b0, 32'h0);
      exp_v = exp_q.pop_front();
      got_v = {o_err, o_done, o_rdata};
      checks++;
      if (got_v !== exp_v || o_edges !== 0 || o_rd || o_wr || o_act !== 0) begin
        failures++;
        $display("FAIL misaligned_%0d: got %h edges=%0d rd=%b wr=%b required %h edges=0 rd=0 wr=0",
                 i, got_v, o_edges, o_rd, o_wr, exp_v);
      end
      @(posedge clk); #1;
      checks++;
      if ({core_err, dbg_state, core_busy} !== 3'b000) begin
        failures++;
        $display("FAIL misaligned_%0d_after: err/state/busy=%b required 000", i, {core_err, dbg_state, core_busy});
      end
    end
  endtask

  task automatic test_random_loads;
    logic [3:0]  idx;
    logic [1:0]  lo, sz;
    logic        sg;
    logic [3:0]  be_e;
    int          st;
    bd_write(4'd12, $urandom());
    for (int i = 0; i < 10; i++) begin
      idx = (i % 3 == 0) ? 4'd4 : ((i % 3 == 1) ? 4'd8 : 4'd12);
      sz  = 2'($urandom_range(0, 2));
      sg  = 1'($urandom_range(0, 1));
      lo  = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : ((sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00);
      st  = $urandom_range(0, 3);
      stalls_cfg = st;
      be_e = (sz == 2'b00) ? (4'b0001 << lo) : ((sz == 2'b01) ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111);
      exp_q.push_back({2'b01, ext(mem[idx], lo, sz, sg)});
      drive_req(1'b0, {26'h0, idx, lo}, sz, sg, 32'h0);
      exp_v = exp_q.pop_front();
      got_v = {o_err, o_done, o_rdata};
      checks++;
      if (got_v !== exp_v || o_be !== be_e || o_edges !== st + 1 || !o_stable) begin
        failures++;
        $display("FAIL random_load_%0d: got %h be=%b edges=%0d stable=%b required %h be=%b edges=%0d stable=1",
                 i, got_v, o_be, o_edges, o_stable, exp_v, be_e, st + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    stalls_cfg = 0;
    exp_q.push_back({2'b01, mem[4]});
    exp_q.push_back({2'b01, mem[8]});
    drive_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v || !o_gap) begin
      failures++;
      $display("FAIL b2b_first: got %h gap=%b required %h gap=1", got_v, o_gap, exp_v);
    end
    drive_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v || !o_rd || o_edges !== 1) begin
      failures++;
      $display("FAIL b2b_second: got %h rd=%b edges=%0d required %h rd=1 edges=1", got_v, o_rd, o_edges, exp_v);
    end
  endtask

  task automatic test_timeout;
    tie_wait = 1'b1;
    exp_q.push_back({2'b10, core_rdata});
    @(posedge clk); #1;
    drive_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL timeout_result: got %h required %h", got_v, exp_v);
    end
    checks++;
    if (o_act !== TO || !o_gap || !o_rd) begin
      failures++;
      $display("FAIL timeout_read_cycles: read high %0d cycles gap=%b required %0d gap=1", o_act, o_gap, TO);
    end
    tie_wait = 1'b0;
  endtask

  task automatic test_reset_mid;
    stalls_cfg = 5;
    core_req = 1'b1; core_write = 1'b0; core_addr = 32'h10; core_size = 2'b10;
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.read, bus.write, core_busy, core_done, core_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_stall: read/write/busy/done/err=%b required 00000",
               {bus.read, bus.write, core_busy, core_done, core_err});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    stalls_cfg = 0;
    exp_q.push_back({2'b01, mem[4]});
    drive_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    exp_v = exp_q.pop_front();
    got_v = {o_err, o_done, o_rdata};
    checks++;
    if (got_v !== exp_v || o_edges !== 1) begin
      failures++;
      $display("FAIL reset_mid_recover: got %h edges=%0d required %h edges=1", got_v, o_edges, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_random_loads();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
